if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 IF_Inst  input  32  fetched instruction, already zeroed upstream on Branch/Jump.
REQ-005 IF_PC  input  32  byte address of IF_Inst.
REQ-006 IF_Valid  input  1  IF_Inst/IF_PC carry a real instruction this cycle.
REQ-007 Stall  input  1  hazard unit request to hold ID contents (load-use).
REQ-008 Flush  input  1  Branch or Jump resolved; discard the instruction in ID.
REQ-009 ID_Inst  output  32  registered instruction for decode; 0 = NOP.
REQ-010 ID_PC  output  32  registered address of ID_Inst.
REQ-011 ID_PC4  output  32  registered ID_PC + 4.
REQ-012 ID_Valid  output  1  ID stage holds a real instruction.
REQ-013 ID_Misalign  output  1  the captured IF_PC had bits [1:0] != 0.
REQ-014 Held  output  1  the register held its contents on the previous edge because of Stall.
REQ-015 Stall_Cnt  output  16  saturating count of stall cycles.
REQ-016 Flush_Cnt  output  16  saturating count of flush cycles.

Function
REQ-017 On each rising clk edge, the update priority SHALL be: Flush, then Stall, then load.
REQ-018 Flush=1 SHALL set ID_Inst=0, ID_PC=0, ID_PC4=0, ID_Valid=0, ID_Misalign=0 and Held=0, regardless of Stall.
REQ-019 Stall=1 with Flush=0 SHALL leave ID_Inst, ID_PC, ID_PC4, ID_Valid and ID_Misalign unchanged and SHALL set Held=1.
REQ-020 A load (Flush=0, Stall=0) SHALL set ID_PC=IF_PC, ID_PC4=(IF_PC+4) mod 2^32 and Held=0.
REQ-021 On a load with IF_Valid=1 and IF_PC[1:0]=0, the block SHALL set ID_Inst=IF_Inst, ID_Valid=1 and ID_Misalign=0.
REQ-022 On a load with IF_Valid=1 and IF_PC[1:0]!=0, the block SHALL set ID_Inst=0, ID_Valid=0 and ID_Misalign=1.
REQ-023 On a load with IF_Valid=0, the block SHALL set ID_Inst=0, ID_Valid=0 and ID_Misalign=0.
REQ-024 Flush_Cnt SHALL increment by 1 on every edge with Flush=1 and SHALL saturate at 16'hFFFF with no wrap.
REQ-025 Stall_Cnt SHALL increment by 1 on every edge with Stall=1 and Flush=0 and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 Neither counter SHALL change on any other edge.
REQ-027 ID_PC4 SHALL wrap modulo 2^32 (for example, IF_PC=32'hFFFFFFFC gives ID_PC4=0).
REQ-028 A Stall held for N consecutive cycles SHALL keep the outputs constant for N edges; the first edge with Stall=0 SHALL load the current IF inputs.
REQ-029 All outputs SHALL be driven from registers only, with no combinational path from any input to any output.

Reset
REQ-030 While rst_n=0, every output SHALL be 0 (ID_Inst, ID_PC, ID_PC4, ID_Valid, ID_Misalign, Held, Stall_Cnt, Flush_Cnt), and this SHALL take effect immediately without waiting for clk.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after rst_n rises SHALL behave per REQ-017 to REQ-023.

Verification
REQ-032 Load: IF_Inst=32'h8C220004, IF_PC=32'h00000010, IF_Valid=1, Stall=0, Flush=0 -> after 1 edge ID_Inst=32'h8C220004, ID_PC=32'h10, ID_PC4=32'h14, ID_Valid=1.
REQ-033 Stall: after REQ-032, Stall=1 for 3 edges with IF_PC changing each cycle -> outputs unchanged, Held=1, Stall_Cnt=3; Stall=0 then loads the new IF_PC.
REQ-034 Simultaneous events: Stall=1 and Flush=1 together -> ID_Inst=0, ID_Valid=0, Held=0, Flush_Cnt+1, Stall_Cnt unchanged.
REQ-035 Misalign and wrap: IF_PC=32'h00000006, IF_Valid=1 -> ID_Inst=0, ID_Valid=0, ID_Misalign=1; IF_PC=32'hFFFFFFFC -> ID_PC4=0.
REQ-036 Saturation: Flush=1 for 65540 cycles -> Flush_Cnt=16'hFFFF and stays there.
REQ-037 Async reset: rst_n driven low between clock edges while ID_Valid=1 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Pipeline register between the fetch (IF) and decode (ID) stages.
//
// On every rising clock edge the register does one of three things, in this
// priority order:
//   Flush - discard whatever is in ID and leave a NOP with no valid bit.
//   Stall - keep the ID contents as they are (load-use hazard).
//   Load  - capture the fetched instruction and its address.
// A fetch from an address that is not word aligned is never passed on as a
// real instruction. It turns into a NOP, and ID_Misalign is raised so that
// later stages can report it.
// Two saturating counters record how many stall cycles and how many flush
// cycles have occurred, for performance monitoring.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   IF_Inst      in  32   fetched instruction (already zeroed upstream on branch/jump)
//   IF_PC        in  32   byte address of IF_Inst
//   IF_Valid     in   1   IF_Inst/IF_PC carry a real instruction
//   Stall        in   1   hold the ID contents
//   Flush        in   1   discard the ID contents
//   ID_Inst      out 32   registered instruction, 0 = NOP
//   ID_PC        out 32   registered address of ID_Inst
//   ID_PC4       out 32   registered ID_PC + 4 (wraps modulo 2^32)
//   ID_Valid     out  1   ID holds a real instruction
//   ID_Misalign  out  1   captured IF_PC was not word aligned
//   Held         out  1   previous edge held the contents because of Stall
//   Stall_Cnt    out 16   saturating count of stall cycles
//   Flush_Cnt    out 16   saturating count of flush cycles
// ---------------------------------------------------------------------------
module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_Inst,
  input  logic [31:0] IF_PC,
  input  logic        IF_Valid,
  input  logic        Stall,
  input  logic        Flush,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic        ID_Valid,
  output logic        ID_Misalign,
  output logic        Held,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
);

  logic        pc_misaligned;
  logic        load_real;
  logic [31:0] pc_plus4;

  // Decide what a load would capture. Only an aligned, valid fetch becomes a
  // real instruction. A valid fetch from a misaligned address becomes a NOP
  // with the misalign flag set. An invalid fetch becomes a plain NOP.
  always_comb begin
    pc_misaligned = (IF_PC[1:0] != 2'b00);
    load_real     = IF_Valid && !pc_misaligned;
    pc_plus4      = IF_PC + 32'd4;
  end

  // Pipeline register state. Flush takes priority over Stall, and Stall
  // takes priority over a normal load. Every output comes straight from this
  // block, so there is no combinational path from any input to any output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_Inst     <= 32'd0;
      ID_PC       <= 32'd0;
      ID_PC4      <= 32'd0;
      ID_Valid    <= 1'b0;
      ID_Misalign <= 1'b0;
      Held        <= 1'b0;
    end else if (Flush) begin
      ID_Inst     <= 32'd0;
      ID_PC       <= 32'd0;
      ID_PC4      <= 32'd0;
      ID_Valid    <= 1'b0;
      ID_Misalign <= 1'b0;
      Held        <= 1'b0;
    end else if (Stall) begin
      Held        <= 1'b1;
    end else begin
      ID_Inst     <= load_real ? IF_Inst : 32'd0;
      ID_PC       <= IF_PC;
      ID_PC4      <= pc_plus4;
      ID_Valid    <= load_real;
      ID_Misalign <= IF_Valid && pc_misaligned;
      Held        <= 1'b0;
    end
  end

  // Event counters. A cycle with both Stall and Flush counts only as a
  // flush, because the flush is what actually happens to the register.
  // Both counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Cnt <= 16'd0;
      Flush_Cnt <= 16'd0;
    end else if (Flush) begin
      if (Flush_Cnt != 16'hFFFF)
        Flush_Cnt <= Flush_Cnt + 16'd1;
    end else if (Stall) begin
      if (Stall_Cnt != 16'hFFFF)
        Stall_Cnt <= Stall_Cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg
// Self-checking bench for if_id_reg. A table of directed vectors with
// hand-computed expected outputs is applied one vector per clock edge. Short
// hand-written sequences then cover asynchronous reset, a flush and stall
// arriving together while reset is low, and saturation of the flush counter.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] IF_Inst;
  logic [31:0] IF_PC;
  logic        IF_Valid;
  logic        Stall;
  logic        Flush;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC4;
  logic        ID_Valid;
  logic        ID_Misalign;
  logic        Held;
  logic [15:0] Stall_Cnt;
  logic [15:0] Flush_Cnt;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        flush;
    logic        stall;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_mis;
    logic        e_held;
    logic [15:0] e_scnt;
    logic [15:0] e_fcnt;
  } vec_t;

  vec_t vecs [13];

  if_id_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IF_Inst     (IF_Inst),
    .IF_PC       (IF_PC),
    .IF_Valid    (IF_Valid),
    .Stall       (Stall),
    .Flush       (Flush),
    .ID_Inst     (ID_Inst),
    .ID_PC       (ID_PC),
    .ID_PC4      (ID_PC4),
    .ID_Valid    (ID_Valid),
    .ID_Misalign (ID_Misalign),
    .Held        (Held),
    .Stall_Cnt   (Stall_Cnt),
    .Flush_Cnt   (Flush_Cnt)
  );

  // 10 ns clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one output value against its expected value.
  task automatic check_field(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare every output of the DUT against the expected values.
  task automatic check_output(input string tag,
                              input logic [31:0] e_inst, input logic [31:0] e_pc,
                              input logic [31:0] e_pc4, input logic e_valid,
                              input logic e_mis, input logic e_held,
                              input logic [15:0] e_scnt, input logic [15:0] e_fcnt);
    check_field({tag, ".ID_Inst"},     ID_Inst,             e_inst);
    check_field({tag, ".ID_PC"},       ID_PC,               e_pc);
    check_field({tag, ".ID_PC4"},      ID_PC4,              e_pc4);
    check_field({tag, ".ID_Valid"},    {31'd0, ID_Valid},    {31'd0, e_valid});
    check_field({tag, ".ID_Misalign"}, {31'd0, ID_Misalign}, {31'd0, e_mis});
    check_field({tag, ".Held"},        {31'd0, Held},        {31'd0, e_held});
    check_field({tag, ".Stall_Cnt"},   {16'd0, Stall_Cnt},   {16'd0, e_scnt});
    check_field({tag, ".Flush_Cnt"},   {16'd0, Flush_Cnt},   {16'd0, e_fcnt});
  endtask

  // Drive the inputs, let one rising edge pass, and settle 1 ns after it.
  task automatic apply_stimulus(input logic flush, input logic stall,
                                input logic valid, input logic [31:0] inst,
                                input logic [31:0] pc);
    Flush    = flush;
    Stall    = stall;
    IF_Valid = valid;
    IF_Inst  = inst;
    IF_PC    = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            flush stall valid inst          pc
    //            e_inst        e_pc          e_pc4         v  mis held scnt   fcnt
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h8C220004, 32'h00000010,
                 32'h8C220004, 32'h00000010, 32'h00000014, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h00000014,
                 32'h8C220004, 32'h00000010, 32'h00000014, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h11111112, 32'h00000018,
                 32'h8C220004, 32'h00000010, 32'h00000014, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h11111113, 32'h0000001C,
                 32'h8C220004, 32'h00000010, 32'h00000014, 1'b1, 1'b0, 1'b1, 16'd3, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h22222222, 32'h00000020,
                 32'h22222222, 32'h00000020, 32'h00000024, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h33333333, 32'h00000024,
                 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000AAAA, 32'h00000006,
                 32'h00000000, 32'h00000006, 32'h0000000A, 1'b0, 1'b1, 1'b0, 16'd3, 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000BBBB, 32'h00000008,
                 32'h00000000, 32'h00000006, 32'h0000000A, 1'b0, 1'b1, 1'b1, 16'd4, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFC,
                 32'h12345678, 32'hFFFFFFFC, 32'h00000000, 1'b1, 1'b0, 1'b0, 16'd4, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00000040,
                 32'h00000000, 32'h00000040, 32'h00000044, 1'b0, 1'b0, 1'b0, 16'd4, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h44444444, 32'h00000044,
                 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd4, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h55555555, 32'h00000003,
                 32'h00000000, 32'h00000003, 32'h00000007, 1'b0, 1'b0, 1'b0, 16'd4, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hCAFEBABE, 32'h00000100,
                 32'hCAFEBABE, 32'h00000100, 32'h00000104, 1'b1, 1'b0, 1'b0, 16'd4, 16'd2};

    // Power-up reset. The outputs must be zero while rst_n is low.
    rst_n    = 1'b0;
    Flush    = 1'b0;
    Stall    = 1'b0;
    IF_Valid = 1'b0;
    IF_Inst  = 32'd0;
    IF_PC    = 32'd0;
    #3;
    check_output("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #9 rst_n = 1'b1;   // released at 12 ns, away from the 15 ns edge

    // Table-driven vectors, one per edge.
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].flush, vecs[i].stall, vecs[i].valid,
                     vecs[i].inst, vecs[i].pc);
      check_output($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_pc,
                   vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_mis,
                   vecs[i].e_held, vecs[i].e_scnt, vecs[i].e_fcnt);
    end

    // Async reset between edges while ID_Valid=1, with a stall and flush
    // pending. The clear must be visible before the next edge.
    #2;
    Flush = 1'b1;
    Stall = 1'b1;
    rst_n = 1'b0;
    #1;
    check_output("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    check_output("rst_hold", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #2 rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0BADF00D, 32'h00000200);
    check_output("post_rst", 32'h0BADF00D, 32'h00000200, 32'h00000204,
                 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);

    // Flush counter saturation.
    Flush = 1'b1;
    Stall = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check_field("sat.Flush_Cnt_fffe", {16'd0, Flush_Cnt}, 32'h0000FFFE);
    @(posedge clk);
    #1;
    check_field("sat.Flush_Cnt_ffff", {16'd0, Flush_Cnt}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    check_output("sat_hold", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
